// File: rtl/descriptor_table_register_bank.sv
// Descriptor-table base/limit register bank (GDTR, IDTR, ...) with a pseudo-descriptor load sequencer and selector limit check.
// Latency: direct write 1 cycle; memory load 1 + words + 1 cycles (zero-wait); limit check 1 cycle.
// Backpressure: mem_read_valid stalls READ indefinitely; load_start is ignored while load_busy is high.
//
// Ports:
//   clock, reset                        rising-edge clock, async active-high reset
//   write_*                             one-cycle direct write of limit/base into write_channel
//   load_start/channel/operand_32       start a 6-byte pseudo-descriptor load into load_channel
//   load_busy, load_done                sequencer not idle / one-cycle commit pulse
//   mem_read_request/offset/valid/data  bus-read handshake; valid completes the current word
//   table_limit, table_base             packed per-channel limits (16b) and bases (32b)
//   check_*                             selector-index limit check, registered result
module descriptor_table_register_bank #(
   parameter int CHANNELS  = 2,
   parameter int BUS_WIDTH = 16,
   parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     write_enable,
   input  logic [CH_W-1:0]          write_channel,
   input  logic [15:0]              write_limit,
   input  logic [31:0]              write_base,
   input  logic                     load_start,
   input  logic [CH_W-1:0]          load_channel,
   input  logic                     load_operand_32,
   output logic                     load_busy,
   output logic                     load_done,
   output logic                     mem_read_request,
   output logic [2:0]               mem_read_offset,
   input  logic                     mem_read_valid,
   input  logic [BUS_WIDTH-1:0]     mem_read_data,
   output logic [CHANNELS*16-1:0]   table_limit,
   output logic [CHANNELS*32-1:0]   table_base,
   input  logic                     check_valid,
   input  logic [CH_W-1:0]          check_channel,
   input  logic [15:0]              check_selector,
   output logic                     check_result_valid,
   output logic                     check_fault
);

   localparam int NWORDS = (BUS_WIDTH == 32) ? 2 : 3;
   localparam int BYTES  = BUS_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        word_count;
   logic [47:0]       buffer;
   logic [47:0]       buffer_next;
   logic [CH_W-1:0]   ld_ch;
   logic              ld_op32;
   logic [15:0]       limit_q [CHANNELS];
   logic [31:0]       base_q  [CHANNELS];
   logic [15:0]       sel_limit;
   logic              last_word;

   assign last_word = mem_read_valid && (word_count == 2'(NWORDS - 1));

   // ---------------- sequencer FSM ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      load_busy        = 1'b0;
      load_done        = 1'b0;
      mem_read_request = 1'b0;
      mem_read_offset  = 3'd0;
      case (state)
         IDLE: begin
            if (load_start) begin
               state_next = READ;
            end
         end
         READ: begin
            load_busy        = 1'b1;
            mem_read_request = 1'b1;
            mem_read_offset  = 3'(int'(word_count) * BYTES);
            if (last_word) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            load_busy  = 1'b1;
            load_done  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------- word assembly ----------------
   // A 32-bit bus needs only the low half of its second word to fill 48 bits.
   generate
      if (BUS_WIDTH == 32) begin : g_bus32
         logic unused_upper;
         assign unused_upper = ^mem_read_data[31:16];
         always_comb begin
            buffer_next = buffer;
            if (word_count == 2'd0) begin
               buffer_next[31:0] = mem_read_data[31:0];
            end else begin
               buffer_next[47:32] = mem_read_data[15:0];
            end
         end
      end else begin : g_bus16
         always_comb begin
            buffer_next = buffer;
            case (word_count)
               2'd0:    buffer_next[15:0]  = mem_read_data[15:0];
               2'd1:    buffer_next[31:16] = mem_read_data[15:0];
               default: buffer_next[47:32] = mem_read_data[15:0];
            endcase
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word_count <= 2'd0;
         buffer     <= 48'd0;
         ld_ch      <= '0;
         ld_op32    <= 1'b0;
      end else if (state == IDLE) begin
         if (load_start) begin
            word_count <= 2'd0;
            ld_ch      <= load_channel;
            ld_op32    <= load_operand_32;
         end
      end else if (state == READ && mem_read_valid) begin
         buffer     <= buffer_next;
         word_count <= word_count + 2'd1;
      end
   end

   // ---------------- table registers ----------------
   // The sequencer commit takes priority over a direct write to the same channel.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            limit_q[i] <= 16'd0;
            base_q[i]  <= 32'd0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (state == COMMIT && ld_ch == CH_W'(i)) begin
               limit_q[i] <= buffer[15:0];
               base_q[i]  <= ld_op32 ? buffer[47:16] : {8'h00, buffer[39:16]};
            end else if (write_enable && write_channel == CH_W'(i)) begin
               limit_q[i] <= write_limit;
               base_q[i]  <= write_base;
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
         assign table_limit[16*g +: 16] = limit_q[g];
         assign table_base[32*g +: 32]  = base_q[g];
      end
   endgenerate

   // ---------------- limit check ----------------
   // Reads the pre-edge limit; an out-of-range channel sees limit 0, so it faults.
   logic unused_rpl;
   assign unused_rpl = ^check_selector[2:0];

   always_comb begin
      sel_limit = 16'd0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (check_channel == CH_W'(i)) begin
            sel_limit = limit_q[i];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         check_result_valid <= 1'b0;
         check_fault        <= 1'b0;
      end else begin
         check_result_valid <= check_valid;
         check_fault        <= check_valid && ({check_selector[15:3], 3'b111} > sel_limit);
      end
   end

endmodule
